// File: rtl/clkdiv_sched.sv
// Shared controller for NCH square-wave divider channels. Each running channel
// toggles hz_out every lim_q+1 cycles; limit changes on a live channel wait for its next wrap.
module clkdiv_sched #(
    parameter  int NCH     = 4,
    parameter  int W       = 8,
    parameter  int DEF_LIM = 3,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [1:0]     cfg_op,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [W-1:0]   cfg_lim,
    output logic [NCH-1:0] hz_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] pend
);

    typedef enum logic [1:0] {
        OP_SET_LIM = 2'b00,
        OP_START   = 2'b01,
        OP_STOP    = 2'b10,
        OP_SYNC    = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PEND = 2'b10
    } state_t;

    state_t         state_q [NCH];
    logic [W-1:0]   lim_q   [NCH];
    logic [W-1:0]   lim_nxt [NCH];
    logic [W-1:0]   cnt     [NCH];

    logic           cmd_acc;
    logic           sync_acc;
    logic [NCH-1:0] hit;
    logic [NCH-1:0] wrap;

    // A channel holding a deferred limit refuses further commands until it wraps.
    always_comb begin
        cfg_ready = 1'b1;
        if (cfg_op != OP_SYNC) begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_ch == CW'(i) && pend[i]) cfg_ready = 1'b0;
            end
        end
    end

    assign cmd_acc  = cfg_valid & cfg_ready;
    assign sync_acc = cmd_acc & (cfg_op == OP_SYNC);

    // Out-of-range channel numbers match no hit bit, so they are accepted and ignored.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            hit[i]  = cmd_acc && (cfg_op != OP_SYNC) && (cfg_ch == CW'(i));
            wrap[i] = (cnt[i] == lim_q[i]);
        end
    end

    // NOTE: every register here, including the per-channel arrays, is cleared by the
    // async reset and assigned with <= so all channels update from the same pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                lim_q[i]   <= W'(DEF_LIM);
                lim_nxt[i] <= '0;
                cnt[i]     <= '0;
            end
            hz_out <= '0;
            tick   <= '0;
            busy   <= '0;
            pend   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync_acc) begin
                    if (state_q[i] == ST_PEND) lim_q[i] <= lim_nxt[i];
                    state_q[i] <= ST_RUN;
                    cnt[i]     <= '0;
                    hz_out[i]  <= 1'b0;
                    tick[i]    <= 1'b0;
                    busy[i]    <= 1'b1;
                    pend[i]    <= 1'b0;
                end else begin
                    case (state_q[i])
                        ST_IDLE: begin
                            cnt[i]    <= '0;
                            hz_out[i] <= 1'b0;
                            tick[i]   <= 1'b0;
                            if (hit[i] && cfg_op == OP_SET_LIM) lim_q[i] <= cfg_lim;
                            if (hit[i] && cfg_op == OP_START) begin
                                state_q[i] <= ST_RUN;
                                busy[i]    <= 1'b1;
                            end
                        end
                        ST_RUN, ST_PEND: begin
                            if (hit[i] && cfg_op == OP_STOP) begin
                                state_q[i] <= ST_IDLE;
                                cnt[i]     <= '0;
                                hz_out[i]  <= 1'b0;
                                tick[i]    <= 1'b0;
                                busy[i]    <= 1'b0;
                            end else begin
                                cnt[i]  <= wrap[i] ? '0 : cnt[i] + W'(1);
                                tick[i] <= wrap[i];
                                if (wrap[i]) hz_out[i] <= ~hz_out[i];
                                // Deferred limit lands exactly on the wrap edge.
                                if (state_q[i] == ST_PEND && wrap[i]) begin
                                    lim_q[i]   <= lim_nxt[i];
                                    state_q[i] <= ST_RUN;
                                    pend[i]    <= 1'b0;
                                end
                                if (hit[i] && cfg_op == OP_SET_LIM) begin
                                    lim_nxt[i] <= cfg_lim;
                                    state_q[i] <= ST_PEND;
                                    pend[i]    <= 1'b1;
                                end
                            end
                        end
                        default: state_q[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Bench for clkdiv_sched: directed scenarios plus random commands against a
// model that tracks each channel by the absolute cycle of its next toggle.
module tb_clkdiv_sched;

    // Five channels make cfg_ch a 3-bit field, so numbers 5..7 are out of range.
    localparam int NCH     = 5;
    localparam int W       = 8;
    localparam int DEF_LIM = 3;
    localparam int CW      = 3;

    localparam logic [1:0] SET   = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] STOP  = 2'b10;
    localparam logic [1:0] SYNC  = 2'b11;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_op = 2'b00;
    logic [CW-1:0]  cfg_ch = '0;
    logic [W-1:0]   cfg_lim = '0;
    logic [NCH-1:0] hz_out, tick, busy, pend;

    int    checks = 0;
    int    failures = 0;
    string cur = "none";
    int    t = 0;
    logic  obs_ready;

    bit [NCH-1:0] m_run, m_pend, m_hz, m_tick;
    int m_lim [NCH];
    int m_nxt [NCH];
    int m_due [NCH];
    int m_last[NCH];

    clkdiv_sched #(.NCH(NCH), .W(W), .DEF_LIM(DEF_LIM)) dut (
        .clk(clk), .nrst(nrst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_op(cfg_op), .cfg_ch(cfg_ch), .cfg_lim(cfg_lim),
        .hz_out(hz_out), .tick(tick), .busy(busy), .pend(pend)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_run = '0; m_pend = '0; m_hz = '0; m_tick = '0;
        for (int i = 0; i < NCH; i++) begin
            m_lim[i] = DEF_LIM; m_nxt[i] = 0; m_due[i] = 0; m_last[i] = 0;
        end
    endfunction

    function automatic bit model_ready(logic [1:0] op, int ch);
        if (op == SYNC) return 1'b1;
        if (ch < NCH && m_pend[ch]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock edge numbered t: toggles fall on the cycle scheduled at the previous start/wrap.
    function automatic void model_edge(bit v, logic [1:0] op, int ch, int lim);
        bit acc  = v && model_ready(op, ch);
        bit sync = acc && (op == SYNC);
        for (int i = 0; i < NCH; i++) begin
            bit h = acc && (op != SYNC) && (ch == i);
            if (sync) begin
                if (m_pend[i]) begin m_lim[i] = m_nxt[i]; m_pend[i] = 1'b0; end
                m_run[i] = 1'b1; m_hz[i] = 1'b0; m_tick[i] = 1'b0;
                m_due[i] = t + m_lim[i] + 1;
                m_last[i] = t;
            end else if (!m_run[i]) begin
                m_hz[i] = 1'b0; m_tick[i] = 1'b0;
                if (h && op == SET) m_lim[i] = lim;
                if (h && op == START) begin
                    m_run[i] = 1'b1; m_due[i] = t + m_lim[i] + 1; m_last[i] = t;
                end
            end else if (h && op == STOP) begin
                m_run[i] = 1'b0; m_hz[i] = 1'b0; m_tick[i] = 1'b0;
            end else begin
                m_tick[i] = (t == m_due[i]);
                if (m_tick[i]) begin
                    m_hz[i] = ~m_hz[i];
                    m_last[i] = t;
                    if (m_pend[i]) begin m_lim[i] = m_nxt[i]; m_pend[i] = 1'b0; end
                    m_due[i] = t + m_lim[i] + 1;
                end
                if (h && op == SET) begin m_pend[i] = 1'b1; m_nxt[i] = lim; end
            end
        end
    endfunction

    // Entered and left at a falling edge; drives one command slot and steps the model.
    task automatic cyc(input bit v, input logic [1:0] op, input int ch, input int lim);
        bit er;
        cfg_valid = v; cfg_op = op; cfg_ch = CW'(ch); cfg_lim = W'(lim);
        er = model_ready(op, ch);
        #1;
        obs_ready = cfg_ready;
        checks++;
        if (cfg_ready !== er) begin
            failures++;
            $display("FAIL %s ready t=%0d got=%b want=%b", cur, t, cfg_ready, er);
        end
        @(posedge clk);
        t++;
        model_edge(v, op, ch, lim);
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if ({hz_out, tick, busy, pend} !== {m_hz, m_tick, m_run, m_pend}) begin
            failures++;
            $display("FAIL %s outputs t=%0d got hz=%b tick=%b busy=%b pend=%b want hz=%b tick=%b busy=%b pend=%b",
                     cur, t, hz_out, tick, busy, pend, m_hz, m_tick, m_run, m_pend);
        end
    endtask

    task automatic test_reset();
        cur = "reset";
        repeat (3) @(negedge clk);
        checks++;
        if ({hz_out, tick, busy, pend} !== '0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset got hz=%b tick=%b busy=%b pend=%b ready=%b want zeros ready=1",
                     hz_out, tick, busy, pend, cfg_ready);
        end
        nrst = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        int ticks = 0, rises = 0;
        logic prev;
        cur = "single";
        cyc(1, SET, 0, 3);
        cyc(1, START, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, SET, 0, 0);
            checks++;
            if (hz_out[0] !== (i == 4)) begin
                failures++;
                $display("FAIL first_rise cycle=%0d got=%b want=%b", i, hz_out[0], i == 4);
            end
        end
        prev = hz_out[0];
        for (int i = 0; i < 16; i++) begin
            cyc(0, SET, 0, 0);
            if (tick[0]) ticks++;
            if (hz_out[0] && !prev) rises++;
            prev = hz_out[0];
        end
        checks++;
        if (ticks != 4 || rises != 2) begin
            failures++;
            $display("FAIL period8 got ticks=%0d rises=%0d want ticks=4 rises=2", ticks, rises);
        end
    endtask

    task automatic test_multi();
        int r1[$], r2[$];
        logic [NCH-1:0] prev;
        cur = "multi";
        cyc(1, SET, 1, 4);
        cyc(1, SET, 2, 12);
        cyc(1, START, 1, 0);
        cyc(1, START, 2, 0);
        checks++;
        if (busy[2:0] !== 3'b111) begin
            failures++;
            $display("FAIL busy3 got=%b want=111", busy[2:0]);
        end
        prev = hz_out;
        for (int i = 0; i < 70; i++) begin
            cyc(0, SET, 0, 0);
            if (hz_out[1] && !prev[1]) r1.push_back(t);
            if (hz_out[2] && !prev[2]) r2.push_back(t);
            prev = hz_out;
        end
        checks++;
        if (r1.size() < 2 || r2.size() < 2 || r1[1] - r1[0] != 10 || r2[1] - r2[0] != 26) begin
            failures++;
            $display("FAIL periods got rises ch1=%0d ch2=%0d p1=%0d p2=%0d want p1=10 p2=26",
                     r1.size(), r2.size(), (r1.size() >= 2) ? r1[1] - r1[0] : -1,
                     (r2.size() >= 2) ? r2[1] - r2[0] : -1);
        end
    endtask

    task automatic test_pend();
        int tprev, tk[$];
        cur = "pend";
        for (int i = 0; i < 10 && (t - (m_due[0] - m_lim[0] - 1)) != 1; i++) cyc(0, SET, 0, 0);
        tprev = m_last[0];
        cyc(1, SET, 0, 1);
        checks++;
        if (pend[0] !== 1'b1) begin
            failures++;
            $display("FAIL pend_set got=%b want=1", pend[0]);
        end
        cyc(1, SET, 0, 9);
        checks++;
        if (obs_ready !== 1'b0) begin
            failures++;
            $display("FAIL pend_ready got=%b want=0", obs_ready);
        end
        for (int i = 0; i < 20 && tk.size() < 3; i++) begin
            cyc(0, SET, 0, 0);
            if (tick[0]) tk.push_back(t);
        end
        checks++;
        if (tk.size() < 3 || tk[0] - tprev != 4 || tk[1] - tk[0] != 2 || tk[2] - tk[1] != 2) begin
            failures++;
            $display("FAIL pend_halves got ticks=%0d gaps=%0d,%0d,%0d want 4,2,2", tk.size(),
                     (tk.size() > 0) ? tk[0] - tprev : -1, (tk.size() > 1) ? tk[1] - tk[0] : -1,
                     (tk.size() > 2) ? tk[2] - tk[1] : -1);
        end
    endtask

    task automatic test_sync();
        int f0 = 0, f1 = 0;
        cur = "sync";
        cyc(1, SET, 0, 3);
        for (int i = 0; i < 10 && m_pend[0]; i++) cyc(0, SET, 0, 0);
        cyc(1, SYNC, 0, 0);
        checks++;
        if (hz_out[2:0] !== 3'b000 || tick !== '0) begin
            failures++;
            $display("FAIL sync_clear got hz=%b tick=%b want hz=000 tick=0", hz_out[2:0], tick);
        end
        for (int i = 1; i <= 6; i++) begin
            cyc(0, SET, 0, 0);
            if (tick[0] && f0 == 0) f0 = i;
            if (tick[1] && f1 == 0) f1 = i;
        end
        checks++;
        if (f0 != 4 || f1 != 5) begin
            failures++;
            $display("FAIL sync_phase got ch0=%0d ch1=%0d want ch0=4 ch1=5", f0, f1);
        end
    endtask

    task automatic test_div2();
        cur = "div2";
        cyc(1, SET, 3, 0);
        cyc(1, START, 3, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc(0, SET, 0, 0);
            checks++;
            if (hz_out[3] !== (i % 2 == 1) || tick[3] !== 1'b1) begin
                failures++;
                $display("FAIL div2 cycle=%0d got hz=%b tick=%b want hz=%b tick=1",
                         i, hz_out[3], tick[3], i % 2 == 1);
            end
        end
        cyc(1, STOP, 3, 0);
        checks++;
        if (hz_out[3] !== 1'b0 || busy[3] !== 1'b0) begin
            failures++;
            $display("FAIL stop got hz=%b busy=%b want 0 0", hz_out[3], busy[3]);
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        cur = "random";
        for (int i = 0; i < 1500; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == SYNC && $urandom_range(0, 3) != 0) op = START;
            cyc(bit'($urandom_range(0, 1)), op, int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
        end
    endtask

    task automatic test_async_reset();
        cur = "async_reset";
        cyc(1, SYNC, 0, 0);
        cyc(1, SET, 0, 6);
        checks++;
        if (pend[0] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_pend got=%b want=1", pend[0]);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({hz_out, tick, busy, pend} !== '0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_clear got hz=%b tick=%b busy=%b pend=%b ready=%b want zeros ready=1",
                     hz_out, tick, busy, pend, cfg_ready);
        end
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
        cyc(1, START, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, SET, 0, 0);
            checks++;
            if (hz_out[0] !== (i == 4)) begin
                failures++;
                $display("FAIL lim_restored cycle=%0d got=%b want=%b", i, hz_out[0], i == 4);
            end
        end
        cur = "out_of_range";
        cyc(1, SET, 5, 9);
        checks++;
        if (obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL oor_ready got=%b want=1", obs_ready);
        end
        cyc(1, START, 5, 0);
        cyc(1, START, 7, 0);
        checks++;
        if (busy !== 5'b00001) begin
            failures++;
            $display("FAIL oor_effect got busy=%b want=00001", busy);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_multi();
        test_pend();
        test_sync();
        test_div2();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
